// File: rtl/silly_function.sv
// Three-input boolean function with a registered copy, index coverage bitmap and a saturating y-high counter.
// y and all_seen are combinational, y_q/seen/ones_cnt update one clk after sampling; there is no backpressure.
module silly_function #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             y,
  output logic             y_q,
  output logic [7:0]       seen,
  output logic [CNT_W-1:0] ones_cnt,
  output logic             all_seen
);

  logic [2:0]       idx;
  logic             y_q_d;
  logic             y_q_q;
  logic [7:0]       seen_d;
  logic [7:0]       seen_q;
  logic [CNT_W-1:0] ones_cnt_d;
  logic [CNT_W-1:0] ones_cnt_q;

  assign idx = {a, b, c};
  assign y   = (~b & ~c) | (a & ~b);

  always_comb begin
    y_q_d       = y;
    seen_d      = seen_q;
    seen_d[idx] = 1'b1;
    ones_cnt_d  = ones_cnt_q;
    // Counter holds at all-ones instead of wrapping.
    if (y && (ones_cnt_q != {CNT_W{1'b1}})) begin
      ones_cnt_d = ones_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q_q      <= 1'b0;
      seen_q     <= 8'h00;
      ones_cnt_q <= '0;
    end else begin
      y_q_q      <= y_q_d;
      seen_q     <= seen_d;
      ones_cnt_q <= ones_cnt_d;
    end
  end

  assign y_q      = y_q_q;
  assign seen     = seen_q;
  assign ones_cnt = ones_cnt_q;
  assign all_seen = &seen_q;

endmodule

// File: tb/tb_silly_function.sv
// Self-checking bench: table sweep, directed corner sequences and random stimulus against a truth-table model.
module tb_silly_function;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a = 1'b0;
  logic        b = 1'b0;
  logic        c = 1'b0;

  logic        y_a, yq_a, all_a;
  logic [7:0]  seen_a;
  logic [15:0] cnt_a;
  logic        y_b, yq_b, all_b;
  logic [7:0]  seen_b;
  logic [3:0]  cnt_b;

  silly_function #(.CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c),
    .y(y_a), .y_q(yq_a), .seen(seen_a), .ones_cnt(cnt_a), .all_seen(all_a)
  );

  silly_function #(.CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c),
    .y(y_b), .y_q(yq_b), .seen(seen_b), .ones_cnt(cnt_b), .all_seen(all_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] abc;
    logic       exp_y;
  } vec_t;

  vec_t       tbl [8];
  logic [7:0] ytab;
  logic [7:0] m_seen;
  logic       m_yq;
  int         m_cnt_a;
  int         m_cnt_b;
  logic [2:0] cur_abc;
  logic       cur_rst;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Apply a vector, then compare everything at the following falling edge.
  task automatic drive(input logic [2:0] abc, input logic rst);
    {a, b, c} = abc;
    reset     = rst;
    cur_abc   = abc;
    cur_rst   = rst;
    @(negedge clk);
    check("y", {31'd0, y_a}, {31'd0, ytab[abc]});
    check("y_w4", {31'd0, y_b}, {31'd0, ytab[abc]});
    check("y_q", {31'd0, yq_a}, {31'd0, m_yq});
    check("seen", {24'd0, seen_a}, {24'd0, m_seen});
    check("ones_cnt", {16'd0, cnt_a}, m_cnt_a);
    check("ones_cnt_w4", {28'd0, cnt_b}, m_cnt_b);
    check("all_seen", {31'd0, all_a}, {31'd0, &m_seen});
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (cur_rst) begin
      m_yq    = 1'b0;
      m_seen  = 8'h00;
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else begin
      m_yq            = ytab[cur_abc];
      m_seen[cur_abc] = 1'b1;
      if (ytab[cur_abc]) begin
        m_cnt_a = (m_cnt_a + 1 > 65535) ? 65535 : m_cnt_a + 1;
        m_cnt_b = (m_cnt_b + 1 > 15) ? 15 : m_cnt_b + 1;
      end
    end
    #1;
  endtask

  task automatic step(input logic [2:0] abc, input logic rst);
    drive(abc, rst);
    clock_edge();
  endtask

  initial begin
    logic [2:0] r;
    ytab = 8'b0011_0001;
    for (int i = 0; i < 8; i++) begin
      tbl[i].abc   = 3'(i);
      tbl[i].exp_y = (i == 0 || i == 4 || i == 5);
    end
    m_yq = 1'b0; m_seen = 8'h00; m_cnt_a = 0; m_cnt_b = 0;
    cur_abc = 3'b000; cur_rst = 1'b1;

    // Reset held from t=0 to t=27 with toggling inputs.
    clock_edge();
    step(3'($urandom), 1'b1);
    step(3'($urandom), 1'b1);
    r = 3'($urandom);
    {a, b, c} = r;
    #1;
    drive(r, 1'b0);
    clock_edge();

    // Clean sweep of all eight indices from a fresh reset.
    step(3'b000, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].abc, 1'b0);
      check("tbl_y", {31'd0, y_a}, {31'd0, tbl[i].exp_y});
      clock_edge();
    end
    drive(3'b111, 1'b0);
    check("sweep_seen", {24'd0, seen_a}, 32'hFF);
    check("sweep_all_seen", {31'd0, all_a}, 32'd1);
    check("sweep_cnt", {16'd0, cnt_a}, 32'd3);
    clock_edge();

    // Latency: y_q follows y one edge later.
    step(3'b100, 1'b0);
    drive(3'b010, 1'b0);
    check("lat_100", {31'd0, yq_a}, 32'd1);
    clock_edge();
    drive(3'b010, 1'b0);
    check("lat_010", {31'd0, yq_a}, 32'd0);
    clock_edge();

    // Saturation on the narrow counter.
    step(3'b000, 1'b1);
    for (int i = 0; i < 20; i++) step(3'b000, 1'b0);
    drive(3'b000, 1'b0);
    check("sat_w4", {28'd0, cnt_b}, 32'd15);
    check("sat_w16", {16'd0, cnt_a}, 32'd20);
    clock_edge();
    drive(3'b000, 1'b0);
    check("sat_w4_hold", {28'd0, cnt_b}, 32'd15);
    clock_edge();

    // Mid-run reset pulse after five vectors; reset wins over a y=1 input.
    step(3'b000, 1'b1);
    step(3'b000, 1'b0);
    step(3'b100, 1'b0);
    step(3'b011, 1'b0);
    step(3'b101, 1'b0);
    step(3'b110, 1'b0);
    step(3'b100, 1'b1);
    drive(3'b101, 1'b0);
    check("midrst_seen", {24'd0, seen_a}, 32'd0);
    check("midrst_cnt", {16'd0, cnt_a}, 32'd0);
    check("midrst_yq", {31'd0, yq_a}, 32'd0);
    clock_edge();
    drive(3'b001, 1'b0);
    check("restart_seen", {24'd0, seen_a}, 32'h20);
    check("restart_cnt", {16'd0, cnt_a}, 32'd1);
    clock_edge();

    // Random stimulus with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(3'($urandom), ($urandom_range(0, 24) == 0));
    end
    drive(3'b000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/silly_function.md
SILLY_FUNCTION -- requirements
Module: silly_function

Interface
REQ-001 Parameter CNT_W, default 16: width of the y-high event counter; legal range 4..32.
REQ-002 clk  input  1  single clock; all sequential state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 a  input  1  function input, most significant bit of the input index {a,b,c}.
REQ-005 b  input  1  function input, middle bit of the input index.
REQ-006 c  input  1  function input, least significant bit of the input index.
REQ-007 y  output  1  combinational function result.
REQ-008 y_q  output  1  y registered on the rising edge of clk.
REQ-009 seen  output  8  coverage bitmap; bit n set once input index {a,b,c}==n has been sampled.
REQ-010 ones_cnt  output  CNT_W  saturating count of rising edges on which y was 1.
REQ-011 all_seen  output  1  combinational AND of all 8 bits of seen.

Function
REQ-012 y SHALL equal (~b & ~c) | (a & ~b), purely combinationally, with no dependence on clk or reset.
REQ-013 The y truth table for {a,b,c} 000..111 SHALL be 1,0,0,0,1,1,0,0.
REQ-014 y SHALL settle within the same cycle in which the inputs change, so a check at the falling edge observes the function of the inputs applied after the preceding rising edge.
REQ-015 y SHALL be valid during reset.
REQ-016 y SHALL never be X or Z when a, b and c are all 0 or 1.
REQ-017 On each rising edge with reset low, y_q SHALL load the current y, giving 1-cycle latency.
REQ-018 On each rising edge with reset low, seen[{a,b,c}] SHALL be set to 1; set bits SHALL remain set until reset.
REQ-019 On each rising edge with reset low and y==1, ones_cnt SHALL increment by 1.
REQ-020 ones_cnt SHALL hold at 2^CNT_W-1 when it reaches that value and SHALL NOT wrap.
REQ-021 Sequential state SHALL NOT update on X input values; the bench SHALL supply known values only.
REQ-022 all_seen SHALL rise combinationally in the cycle after the eighth distinct index is sampled.

Reset
REQ-023 With reset high at a rising edge, y_q SHALL be 0, seen SHALL be 8'h00 and ones_cnt SHALL be 0.
REQ-024 Reset SHALL take priority over the updates in REQ-017 to REQ-020 when both occur on the same edge.
REQ-025 Reset asserted mid-operation SHALL clear all state on the next rising edge, and counting SHALL resume on the first edge with reset low.
REQ-026 Reset SHALL have no effect on the combinational output y.

Verification
REQ-027 Exhaustive check: apply {a,b,c}=000..111, one vector per cycle, at posedge+1 and check y at negedge -> 1,0,0,0,1,1,0,0 with 0 errors.
REQ-028 Reset check: hold reset 27 time units with 10-unit clock and inputs toggling -> y follows the function throughout, y_q=0, seen=0, ones_cnt=0 while reset is high.
REQ-029 Coverage check: after the 8-vector sweep with reset low -> seen=8'hFF, all_seen=1, ones_cnt=3.
REQ-030 Latency check: apply {a,b,c}=100 then 010 -> y_q is 1 one cycle after the 100 vector and 0 one cycle after the 010 vector.
REQ-031 Saturation check: with CNT_W=4, hold {a,b,c}=000 for 20 cycles -> ones_cnt stays at 15.
REQ-032 Mid-run reset check: pulse reset for 1 cycle after 5 vectors -> seen=0 and ones_cnt=0, then accumulation restarts.
